dwa_element_selector: RTL
=========================

Name: dwa_element_selector

Overview:
- Back end of the quantizer path. Takes the registered multi-bit quantizer code and drives the unit-element enables of the multi-bit DAC.
- Uses data-weighted averaging (DWA) to apply dynamic element matching: a rotating pointer spreads element usage evenly, which first-order shapes element-mismatch error.
- A bypass mode produces a plain thermometer code, for characterisation.
- Sits between the quantizer output register and the DAC unit-element drivers. One code is consumed per valid cycle.

Parameters:
- CODE_WIDTH, 3, width of the quantizer code input.
- NUM_ELEM, (1<<CODE_WIDTH)-1 = 7, number of unit DAC elements. Derived localparam, not overridable.
- PTR_WIDTH, $clog2(NUM_ELEM) = 3, pointer width. Derived localparam.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- code_i  input  CODE_WIDTH  unsigned quantizer code k, range 0..NUM_ELEM.
- code_valid_i  input  1  code_i is sampled on this edge.
- dem_en_i  input  1  1 = DWA rotation, 0 = static thermometer.
- ptr_clr_i  input  1  synchronous pointer clear.
- elem_sel_o  output  NUM_ELEM  unit-element enables, bit i drives element i.
- sel_valid_o  output  1  one-cycle pulse: elem_sel_o was updated this cycle.
- ptr_o  output  PTR_WIDTH  current DWA pointer (next start element).
- ptr_wrap_o  output  1  one-cycle pulse: the last selection wrapped past element NUM_ELEM-1.

Behaviour:
- Reset (async, rst_i=1): elem_sel_o=0, sel_valid_o=0, ptr_o=0, ptr_wrap_o=0. Takes effect immediately, including mid-stream; there is no drain and any in-flight code is discarded.
- Latency is 1 cycle. A code sampled on edge n is reflected in elem_sel_o, sel_valid_o, ptr_o and ptr_wrap_o after edge n. All outputs are registered.
- No valid (code_valid_i=0):
  - elem_sel_o holds its previous value, because the DAC holds its level.
  - sel_valid_o=0, ptr_wrap_o=0, ptr_o unchanged.
- Effective start pointer p:
  - p = 0 if ptr_clr_i=1 or dem_en_i=0;
  - otherwise p = ptr_o.
- DWA mode (dem_en_i=1, code_valid_i=1):
  - elem_sel_o bit i = 1 exactly for i in {p, p+1, ..., p+k-1} mod NUM_ELEM, so popcount(elem_sel_o) = k.
  - ptr_o <= (p+k) mod NUM_ELEM. The modulo is not a power of two, so use compare-and-subtract on a PTR_WIDTH+1 sum; the sum is at most 2*NUM_ELEM-1, so one subtraction suffices.
  - ptr_wrap_o <= 1 iff k>0 and p+k >= NUM_ELEM.
- Thermometer mode (dem_en_i=0, code_valid_i=1):
  - elem_sel_o bits 0..k-1 set.
  - ptr_o <= 0, ptr_wrap_o <= 0.
- k=0: elem_sel_o=0, ptr_o <= p, ptr_wrap_o=0, sel_valid_o=1.
- k=NUM_ELEM: elem_sel_o all ones, ptr_o <= p (full rotation), ptr_wrap_o=1 in DWA mode.
- ptr_clr_i with code_valid_i=0: ptr_o <= 0, elem_sel_o held, no pulses.
- ptr_clr_i with code_valid_i=1: the clear applies before the sample, so the selection starts at element 0 and ptr_o <= k mod NUM_ELEM.
- dem_en_i toggling: takes effect on the sample at which it is seen. No pipeline state other than the pointer, so there are no glitch cycles.
- Codes above NUM_ELEM are not representable, since NUM_ELEM = 2^CODE_WIDTH-1. No saturation logic is needed.

Decomposition:
- Package dem_pkg:
  - CODE_WIDTH, NUM_ELEM, PTR_WIDTH constants;
  - typedefs code_t, ptr_t, elem_vec_t;
  - function ptr_add_mod(ptr_t, code_t), shared with future DEM variants (e.g. bi-directional DWA).
- One sub-module: therm_decoder, a combinational code_t -> elem_vec_t thermometer.
- The top level does the circular left-rotate by p, implemented as a doubled vector (2*NUM_ELEM) shifted then OR-folded. It also holds the pointer register and the output registers.

Test Plan:
- Reset: assert rst_i asynchronously mid-stream with ptr_o=5 -> elem_sel_o=0000000, ptr_o=0 and both pulses 0 immediately, with no clock edge needed.
- DWA sequence: dem_en=1, codes 3,3,3 on consecutive cycles -> elem_sel_o = 0000111, 0111000, 1000011; ptr_o = 3, 6, 2; ptr_wrap_o high only on the third result.
- Full scale: at ptr_o=2, code 7 -> elem_sel_o=1111111, ptr_o stays 2, ptr_wrap_o=1. Then code 0 -> elem_sel_o=0000000, sel_valid_o=1, ptr_o=2, no wrap.
- Bypass: dem_en=0, code 5 with ptr_o=4 -> elem_sel_o=0011111, ptr_o=0. Then dem_en=1, code 2 -> 0000011, ptr_o=2.
- Clear with sample: ptr_o=6, ptr_clr_i=1 and code 4 together -> elem_sel_o=0001111, ptr_o=4. ptr_clr_i alone -> ptr_o=0, elem_sel_o held.
- Randomized mismatch check: 10k random valid/idle codes in DWA mode -> each cycle popcount(elem_sel_o)=k. The cumulative per-element usage counts never differ by more than 1 at any point.

Source files
------------

// File: rtl/dem_pkg.sv
// Shared constants, types and pointer arithmetic for the DAC element-selection
// (dynamic element matching) logic.
//   CODE_WIDTH : quantizer code width
//   NUM_ELEM   : unit DAC elements, 2^CODE_WIDTH-1
//   PTR_WIDTH  : DWA pointer width
package dem_pkg;

    localparam int unsigned CODE_WIDTH = 3;
    localparam int unsigned NUM_ELEM   = (1 << CODE_WIDTH) - 1;
    localparam int unsigned PTR_WIDTH  = $clog2(NUM_ELEM);

    typedef logic [CODE_WIDTH-1:0] code_t;
    typedef logic [PTR_WIDTH-1:0]  ptr_t;
    typedef logic [PTR_WIDTH:0]    ptr_sum_t;
    typedef logic [NUM_ELEM-1:0]   elem_vec_t;
    typedef logic [2*NUM_ELEM-1:0] elem_dbl_t;

    localparam ptr_sum_t NUM_ELEM_SUM = ptr_sum_t'(NUM_ELEM);

    // Pointer plus code, one bit wider so the carry past NUM_ELEM is visible.
    function automatic ptr_sum_t ptr_sum(input ptr_t p, input code_t k);
        return ptr_sum_t'(p) + ptr_sum_t'(k);
    endfunction

    // (p + k) mod NUM_ELEM. The sum never reaches 2*NUM_ELEM, so a single
    // conditional subtraction is enough.
    function automatic ptr_t ptr_add_mod(input ptr_t p, input code_t k);
        ptr_sum_t s;
        s = ptr_sum(p, k);
        if (s >= NUM_ELEM_SUM) begin
            s = s - NUM_ELEM_SUM;
        end
        return s[PTR_WIDTH-1:0];
    endfunction

    // True when a non-empty selection starting at p runs past element NUM_ELEM-1.
    function automatic logic ptr_add_wraps(input ptr_t p, input code_t k);
        return (k != '0) && (ptr_sum(p, k) >= NUM_ELEM_SUM);
    endfunction

endpackage

// File: rtl/therm_decoder.sv
// Combinational binary-to-thermometer decoder.
//   code_i  : unsigned code k, 0..NUM_ELEM
//   therm_o : bits 0..k-1 set, others clear
module therm_decoder
    import dem_pkg::*;
(
    input  logic [CODE_WIDTH-1:0] code_i,
    output logic [NUM_ELEM-1:0]   therm_o
);

    always_comb begin
        therm_o = '0;
        for (int i = 0; i < int'(NUM_ELEM); i++) begin
            therm_o[i] = (code_i > code_t'(i));
        end
    end

endmodule

// File: rtl/dwa_element_selector.sv
// Data-weighted-averaging unit-element selector for the multi-bit DAC.
// Each valid code k enables k consecutive elements (circularly) starting at the
// rotating pointer; bypass mode emits a plain thermometer code from element 0.
//   clk_i, rst_i : clock, async active-high reset
//   code_i       : quantizer code k
//   code_valid_i : sample code_i on this edge
//   dem_en_i     : 1 = DWA rotation, 0 = thermometer
//   ptr_clr_i    : synchronous pointer clear (applies before a same-cycle sample)
//   elem_sel_o   : element enables, held between valid codes
//   sel_valid_o  : pulse, elem_sel_o updated
//   ptr_o        : next start element
//   ptr_wrap_o   : pulse, last selection wrapped past element NUM_ELEM-1
module dwa_element_selector
    import dem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CODE_WIDTH-1:0] code_i,
    input  logic                  code_valid_i,
    input  logic                  dem_en_i,
    input  logic                  ptr_clr_i,
    output logic [NUM_ELEM-1:0]   elem_sel_o,
    output logic                  sel_valid_o,
    output logic [PTR_WIDTH-1:0]  ptr_o,
    output logic                  ptr_wrap_o
);

    elem_vec_t r_elem_sel, w_elem_sel_d;
    logic      r_sel_valid, w_sel_valid_d;
    ptr_t      r_ptr, w_ptr_d;
    logic      r_wrap, w_wrap_d;

    ptr_t      w_p;
    elem_vec_t w_therm;
    elem_dbl_t w_dbl;
    elem_vec_t w_rot;

    // Effective start element for this sample.
    assign w_p = (ptr_clr_i || !dem_en_i) ? '0 : r_ptr;

    therm_decoder u_therm (
        .code_i  (code_i),
        .therm_o (w_therm)
    );

    // Circular rotate-left by w_p: shift into a doubled vector, then fold the
    // bits that spilled past NUM_ELEM-1 back onto the low elements.
    assign w_dbl = elem_dbl_t'(w_therm) << w_p;
    assign w_rot = w_dbl[NUM_ELEM-1:0] | w_dbl[2*NUM_ELEM-1:NUM_ELEM];

    always_comb begin
        w_elem_sel_d  = r_elem_sel;
        w_sel_valid_d = 1'b0;
        w_ptr_d       = ptr_clr_i ? '0 : r_ptr;
        w_wrap_d      = 1'b0;
        if (code_valid_i) begin
            w_elem_sel_d  = w_rot;
            w_sel_valid_d = 1'b1;
            if (dem_en_i) begin
                w_ptr_d  = ptr_add_mod(w_p, code_i);
                w_wrap_d = ptr_add_wraps(w_p, code_i);
            end else begin
                w_ptr_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_elem_sel  <= '0;
            r_sel_valid <= 1'b0;
            r_ptr       <= '0;
            r_wrap      <= 1'b0;
        end else begin
            r_elem_sel  <= w_elem_sel_d;
            r_sel_valid <= w_sel_valid_d;
            r_ptr       <= w_ptr_d;
            r_wrap      <= w_wrap_d;
        end
    end

    assign elem_sel_o  = r_elem_sel;
    assign sel_valid_o = r_sel_valid;
    assign ptr_o       = r_ptr;
    assign ptr_wrap_o  = r_wrap;

endmodule
